barrett_pipelined: RTL and testbench



---
 rtl/barrett_pipelined.sv | 150 +++++++++++++++
 tb/tb_barrett_pipelined.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/barrett_pipelined.sv
// barrett_pipelined: fully pipelined Barrett modular reducer, result_o = x_i mod m_i.
// One beat per clock, results leave in order LATENCY cycles after capture.
// Optional feature macro: BARRETT_ERR_EN adds err_o, flagging a residue that
// is still >= m after the two final corrections (bad mu, k or operand range).
module barrett_pipelined #(
   parameter int WIDTH   = 64,
   parameter int LATENCY = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] m_i,
   input  logic [WIDTH-1:0] m_bl_i,
   input  logic [WIDTH-1:0] mu_i,
   output logic [WIDTH-1:0] result_o,
   output logic             valid_o
`ifdef BARRETT_ERR_EN
   ,
   output logic             err_o
`endif
);

   localparam int KW = 7;
   localparam int unusedLatency = LATENCY;

   logic                 v1_q, v2_q, v3_q, v4_q, valid_q;
   logic [WIDTH-1:0]     x1_q, x2_q, x3_q;
   logic [WIDTH-1:0]     m1_q, m2_q, m3_q, m4_q;
   logic [WIDTH-1:0]     mu1_q;
   logic [KW-1:0]        k1_q, k2_q;
   logic [2*WIDTH-1:0]   p2_q, p2_d;
   logic [WIDTH+1:0]     qm3_q, qm3_d;
   logic [WIDTH+1:0]     r4_q, r4_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic [WIDTH-1:0]     t1;
   logic [2*WIDTH-1:0]   q2;
   logic [WIDTH+1:0]     mExt, rOnce, rTwice;
   logic                 errD;
   logic                 unusedBits;

   // Stage 1: capture the operand and its per-beat modulus, mu and bit length
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v1_q  <= 1'b0;
         x1_q  <= '0;
         m1_q  <= '0;
         mu1_q <= '0;
         k1_q  <= '0;
      end else begin
         v1_q  <= start_i;
         x1_q  <= x_i;
         m1_q  <= m_i;
         mu1_q <= mu_i;
         k1_q  <= m_bl_i[KW-1:0];
      end
   end

   // Stage 2 datapath: t = x >> (k-1), then the full-width product t * mu
   always_comb begin
      t1   = x1_q >> (k1_q - 7'd1);
      p2_d = {{WIDTH{1'b0}}, t1} * {{WIDTH{1'b0}}, mu1_q};
   end

   // Stage 3 datapath: quotient estimate q = p >> (k+1), qm kept to WIDTH+2 bits
   always_comb begin
      q2    = p2_q >> ({1'b0, k2_q} + 8'd1);
      qm3_d = q2[WIDTH+1:0] * {2'b00, m2_q};
   end

   // Stage 4 datapath: raw residue, which is below 3m for a valid beat
   always_comb begin
      r4_d = {2'b00, x3_q} - qm3_q;
   end

   // Final corrections: subtract m at most twice while the residue is still >= m
   always_comb begin
      mExt     = {2'b00, m4_q};
      rOnce    = (r4_q >= mExt) ? (r4_q - mExt) : r4_q;
      rTwice   = (rOnce >= mExt) ? (rOnce - mExt) : rOnce;
      result_d = rTwice[WIDTH-1:0];
      errD     = (rTwice >= mExt);
   end

   // Pipeline registers between stages; the modulus and k travel with their beat
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         v4_q  <= 1'b0;
         x2_q  <= '0;
         x3_q  <= '0;
         m2_q  <= '0;
         m3_q  <= '0;
         m4_q  <= '0;
         k2_q  <= '0;
         p2_q  <= '0;
         qm3_q <= '0;
         r4_q  <= '0;
      end else begin
         v2_q  <= v1_q;
         v3_q  <= v2_q;
         v4_q  <= v3_q;
         x2_q  <= x1_q;
         x3_q  <= x2_q;
         m2_q  <= m1_q;
         m3_q  <= m2_q;
         m4_q  <= m3_q;
         k2_q  <= k1_q;
         p2_q  <= p2_d;
         qm3_q <= qm3_d;
         r4_q  <= r4_d;
      end
   end

   // Output register: result only updates on a valid beat so it holds across bubbles
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q  <= 1'b0;
         result_q <= '0;
      end else begin
         valid_q <= v4_q;
         if (v4_q) begin
            result_q <= result_d;
         end
      end
   end

   assign result_o = result_q;
   assign valid_o  = valid_q;

`ifdef BARRETT_ERR_EN
   logic err_q;

   // Error flag register, aligned with valid_o and held like result_o
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (v4_q) begin
         err_q <= errD;
      end
   end

   assign err_o      = err_q;
   assign unusedBits = ^{m_bl_i[WIDTH-1:KW], q2[2*WIDTH-1:WIDTH+2], rTwice[WIDTH+1:WIDTH]};
`else
   assign unusedBits = ^{m_bl_i[WIDTH-1:KW], q2[2*WIDTH-1:WIDTH+2], rTwice[WIDTH+1:WIDTH], errD};
`endif

endmodule

// File: tb/tb_barrett_pipelined.sv
// tb_barrett_pipelined: scoreboard bench for barrett_pipelined.
// Stimulus pushes the expected residue (x % m) and its capture cycle; a monitor
// pops and compares whenever valid_o is high and checks result_o holds otherwise.
module tb_barrett_pipelined;

   localparam logic [63:0] M  = 64'h3A32E4C4C7A8C21B;
   localparam logic [63:0] MU = 64'h466123E72A6BDD53;
   localparam logic [63:0] K  = 64'd62;

   typedef struct {
      logic [63:0] value;
      int          capture;
   } expT;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b1;
   logic        start_i = 1'b0;
   logic [63:0] x_i = '0;
   logic [63:0] m_i = '0;
   logic [63:0] m_bl_i = '0;
   logic [63:0] mu_i = '0;
   logic [63:0] result_o;
   logic        valid_o;
`ifdef BARRETT_ERR_EN
   logic        err_o;
`endif

   expT         expQ[$];
   int          checks = 0;
   int          failures = 0;
   int          cycleCount = 0;
   logic [63:0] lastResult = '0;

   barrett_pipelined dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .start_i (start_i),
      .x_i     (x_i),
      .m_i     (m_i),
      .m_bl_i  (m_bl_i),
      .mu_i    (mu_i),
      .result_o(result_o),
      .valid_o (valid_o)
`ifdef BARRETT_ERR_EN
      ,
      .err_o   (err_o)
`endif
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to measure capture-to-output latency
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Single comparison point: counts every check and reports any difference
   task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor body: pop and compare on valid_o, otherwise result_o must hold
   task automatic checkOutput();
      expT e;
      if (valid_o === 1'b1) begin
         if (expQ.size() == 0) begin
            checkEq("unexpected_valid", 64'd1, 64'd0);
         end else begin
            e = expQ.pop_front();
            checkEq("result", result_o, e.value);
            checkEq("latency", 64'(cycleCount - e.capture), 64'd4);
`ifdef BARRETT_ERR_EN
            checkEq("err", {63'd0, err_o}, 64'd0);
`endif
            lastResult = e.value;
         end
      end else begin
         checkEq("hold_valid_low", {63'd0, valid_o}, 64'd0);
         checkEq("hold_result", result_o, lastResult);
      end
   endtask

   // Monitor process, decoupled from stimulus, sampling on the falling edge
   always @(negedge clk) begin
      if (rst_ni) checkOutput();
   end

   // Drive one beat (or a bubble with junk data) just after a rising edge
   task automatic applyStimulus(input bit v, input logic [63:0] x, input logic [63:0] m,
                                input logic [63:0] k, input logic [63:0] mu,
                                input logic [63:0] exp);
      expT e;
      @(posedge clk);
      #1;
      start_i = v;
      x_i     = v ? x : {$urandom, $urandom};
      m_i     = m;
      m_bl_i  = k;
      mu_i    = mu;
      if (v) begin
         e.value   = exp;
         e.capture = cycleCount + 1;
         expQ.push_back(e);
      end
   endtask

   // Random legal modulus with its bit length and exact Barrett constant
   task automatic makeModulus(output logic [63:0] m, output logic [63:0] k,
                              output logic [63:0] mu, output logic [63:0] x);
      int           kk;
      logic [63:0]  lo;
      logic [63:0]  r;
      logic [127:0] four;
      kk   = $urandom_range(2, 63);
      lo   = 64'd1 << (kk - 1);
      r    = {$urandom, $urandom};
      m    = lo + 64'd1 + (r % lo);
      four = 128'd1 << (2 * kk);
      mu   = 64'(four / {64'd0, m});
      k    = 64'(kk);
      x    = {$urandom, $urandom};
      if (2 * kk < 64) x = x & ((64'd1 << (2 * kk)) - 64'd1);
   endtask

   // Wait (bounded) for every outstanding beat to emerge
   task automatic drain();
      for (int i = 0; i < 30 && expQ.size() != 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      checkEq("drain_empty", 64'(expQ.size()), 64'd0);
   endtask

   // Main stimulus sequence
   initial begin
      logic [63:0] x, m, k, mu;

      #1 rst_ni = 1'b0;
      #1;
      checkEq("reset_valid", {63'd0, valid_o}, 64'd0);
      checkEq("reset_result", result_o, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_ni = 1'b1;

      // Single beat then idle
      applyStimulus(1, 64'd0, M, K, MU, 64'd0);
      repeat (6) applyStimulus(0, 64'd0, M, K, MU, 64'd0);

      // Directed values back to back
      applyStimulus(1, M, M, K, MU, 64'd0);
      applyStimulus(1, M - 64'd1, M, K, MU, 64'h3A32E4C4C7A8C21A);
      applyStimulus(1, 64'h7465C9898F51843B, M, K, MU, 64'd5);
      applyStimulus(1, 64'hFFFFFFFFFFFFFFFF, M, K, MU, 64'h17346CECE15CF793);
      applyStimulus(0, 64'd0, M, K, MU, 64'd0);

      // Stream of 49 random operands with the fixed modulus
      for (int i = 0; i < 49; i++) begin
         x = {$urandom, $urandom};
         applyStimulus(1, x, M, K, MU, x % M);
      end
      applyStimulus(0, 64'd0, M, K, MU, 64'd0);
      drain();

      // Beat, bubble, beat
      x = {$urandom, $urandom};
      applyStimulus(1, x, M, K, MU, x % M);
      applyStimulus(0, 64'd0, M, K, MU, 64'd0);
      x = {$urandom, $urandom};
      applyStimulus(1, x, M, K, MU, x % M);
      applyStimulus(0, 64'd0, M, K, MU, 64'd0);
      drain();

      // Per-beat random moduli with occasional bubbles
      for (int i = 0; i < 60; i++) begin
         makeModulus(m, k, mu, x);
         if ($urandom_range(0, 3) == 0) applyStimulus(0, x, m, k, mu, 64'd0);
         else applyStimulus(1, x, m, k, mu, x % m);
      end
      applyStimulus(0, 64'd0, M, K, MU, 64'd0);
      drain();

      // Reset with three beats in flight
      for (int i = 0; i < 3; i++) begin
         x = {$urandom, $urandom};
         applyStimulus(1, x, M, K, MU, x % M);
      end
      @(posedge clk);
      #1 start_i = 1'b0;
      expQ.delete();
      lastResult = '0;
      rst_ni = 1'b0;
      #1;
      checkEq("midreset_valid", {63'd0, valid_o}, 64'd0);
      checkEq("midreset_result", result_o, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_ni = 1'b1;
      repeat (8) applyStimulus(0, 64'd0, M, K, MU, 64'd0);

      // Pipeline still works after the flush
      applyStimulus(1, 64'h7465C9898F51843B, M, K, MU, 64'd5);
      applyStimulus(0, 64'd0, M, K, MU, 64'd0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
